frame_aligner_tx: RTL
=====================

# frame_aligner_tx

Transmit-side counterpart of the GTX receive data extractor. Accepts 30-bit payload words over a valid/ready handshake and buffers them in a small FIFO. Each output word carries a 2-bit header in bits [1:0]: a data header for payload words, an idle header with a fixed idle payload when no data is sent. A programmable 0–31 bit serial delay, stepped by a slip pulse, lets the bench and link bring-up exercise the receiver's bit-alignment search.

## Interface

Parameters:
- HDR_DATA, 2'b10, header placed in bits [1:0] of a payload word
- HDR_IDLE, 2'b01, header placed in bits [1:0] of an idle word
- IDLE_WORD, 30'h2AAAAAAA, payload field of an idle word
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW

Ports:
- clk  in  1  160 MHz TX user clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- pld_data  in  30  payload word
- pld_valid  in  1  pld_data valid
- pld_ready  out  1  FIFO can accept a word
- tx_enb  in  1  high: FIFO may be drained; low: idle words only, FIFO holds its contents
- slip_later  in  1  single-cycle pulse: delay the output stream by one more bit
- dataout  out  32  word to the GTX TX data port; bit 0 is transmitted first
- delay  out  5  current bit delay, 0–31
- fifo_level  out  FIFO_AW+1  number of words in the FIFO

## Operation

- Reset is asynchronous. All state is cleared: FIFO pointers, level, frame word, history, delay and dataout are 0.
- While rst_n = 0, pld_ready = 0.
- After reset, dataout stays 0 until the pipeline fills (3 edges), then carries idle words.
- FIFO write: a word is written when pld_valid && pld_ready.
- pld_ready = rst_n && (fifo_level < 2**FIFO_AW). It is combinational from the registered level.
- FIFO read: a word is popped when tx_enb && (fifo_level != 0), one word per clock.
- Simultaneous write and read: the level is unchanged. A write in the cycle the FIFO is full is not possible, because ready is low.
- A word written at edge E is visible for a read in the next cycle, not the same cycle. There is no write-to-read bypass.
- Frame register frame_w, 32 bits, loaded every edge:
  - on a pop: {fifo_head, HDR_DATA}
  - otherwise: {IDLE_WORD, HDR_IDLE}
  - Every clock produces exactly one word; there are no gaps.
- History register hist[63:0] <= {frame_w, hist[63:32]}.
- Output: dataout <= hist[63-delay -: 32], registered.
  - delay = 0 passes frame_w unshifted, one word later.
  - delay = d shifts the serial stream d bits later. The low d bits of the output come from the top d bits of the previous word.
- Slip:
  - On slip_later, delay increments at that edge, wrapping 31 -> 0.
  - A step from d to d+1 inserts exactly one repeated bit into the serial stream.
  - The wrap 31 -> 0 advances the stream by 31 bits. This matches the receiver's counter wrap.
  - delay changes only on slip_later and reset. tx_enb has no effect on it.
- Reset mid-operation flushes the FIFO; buffered words are lost. pld_ready drops immediately.

## Timing

- Latency from accept to output, with the FIFO empty, tx_enb = 1 and delay = 0:
  - the word is accepted at edge E
  - popped into frame_w at E+1
  - enters hist[63:32] at E+2
  - appears on dataout after E+3
- Each word already queued ahead adds one cycle.
- A new delay takes effect on dataout at the edge after the slip_later edge. That output word is a mix of old and new alignment only in the sense defined by the window select; no extra bubble is inserted.
- fifo_level and pld_ready update at the edge following a write or read.
- slip_later held high for N cycles increments delay N times, modulo 32.

## Test plan

- **Reset idle:**
  - Release rst_n with tx_enb = 0 and no payload.
  - dataout = 0 for 3 edges, then 32'hAAAAAAA9 every cycle.
  - pld_ready = 1, fifo_level = 0, delay = 0.
- **Single word latency:**
  - Present 30'h12345678 for one cycle with tx_enb = 1.
  - dataout = {30'h12345678, 2'b10} = 32'h48D159E2, 3 edges after the accept, for exactly one cycle; idle words before and after.
- **FIFO full/backpressure:**
  - With tx_enb = 0, offer 6 consecutive words.
  - 4 are accepted; pld_ready drops after the 4th; fifo_level = 4.
  - Raise tx_enb: the 4 words emerge back-to-back in order, then idle; pld_ready returns to 1 one edge after the first pop.
- **Bit slip:**
  - Stream idle, pulse slip_later once; delay = 1.
  - The serialized stream (LSB first) equals the original delayed by one bit.
  - A data word's header now sits in dataout[2:1].
- **Wrap:**
  - Pulse slip_later 32 times; delay returns to 0.
  - The serial stream shows a net 31-bit advance at the wrap point.
  - Headers are back at bits [1:0].
- **Async reset mid-burst:**
  - Assert rst_n low between edges with 3 words queued.
  - All outputs go to 0 immediately; pld_ready = 0.
  - After release, fifo_level = 0 and no stale data appears.

Source files
------------

// File: rtl/frame_aligner_tx.sv
// frame_aligner_tx
//   Transmit-side framer for a GTX lane. Payload words arrive over a
//   valid/ready handshake into a small FIFO. Every clock produces one 32-bit
//   word: a payload word {data, HDR_DATA} when the FIFO is drained, otherwise
//   an idle word {IDLE_WORD, HDR_IDLE}. A 0..31 bit serial delay, stepped by
//   slip_later, shifts the transmitted bit stream so the receiver's bit
//   alignment search can be exercised.
//
// Ports
//   clk         TX user clock, the only clock
//   rst_n       asynchronous active-low reset
//   pld_data    30-bit payload word
//   pld_valid   pld_data is valid
//   pld_ready   FIFO can accept a word (low while in reset)
//   tx_enb      1: FIFO may be drained, 0: idle words only, FIFO holds
//   slip_later  single-cycle pulse: delay the stream by one more bit
//   dataout     word to the GTX TX data port, bit 0 transmitted first
//   delay       current bit delay 0..31
//   fifo_level  number of words held in the FIFO

module frame_aligner_tx #(
  parameter logic [1:0]  HDR_DATA  = 2'b10,
  parameter logic [1:0]  HDR_IDLE  = 2'b01,
  parameter logic [29:0] IDLE_WORD = 30'h2AAAAAAA,
  parameter int          FIFO_AW   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [29:0]        pld_data,
  input  logic               pld_valid,
  output logic               pld_ready,
  input  logic               tx_enb,
  input  logic               slip_later,
  output logic [31:0]        dataout,
  output logic [4:0]         delay,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int               DEPTH    = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [29:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               push;
  logic               pop;

  // Ready depends on rst_n directly so it drops the instant reset asserts,
  // without waiting for the level register to clear.
  assign pld_ready = rst_n && (fifo_level < FULL_LVL);
  assign push      = pld_valid && pld_ready;
  // Pop uses the registered level, so a word written this edge is not
  // readable until the next cycle (no write-to-read bypass).
  assign pop       = tx_enb && (fifo_level != '0);

  // NOTE: the storage array has no reset; the level/pointers guard every read,
  // so clearing it would only cost reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= pld_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, matching the pipeline timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (FIFO_AW + 1)'(1);
        2'b01:   fifo_level <= fifo_level - (FIFO_AW + 1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Framing, history and bit-delay window
  // ---------------------------------------------------------------------------
  logic [31:0] frame_w;
  logic [31:0] frame_nxt;
  logic [63:0] hist;
  logic [5:0]  top_idx;

  // NOTE: combinational block assigns frame_nxt on every path, so no latch.
  always_comb begin
    frame_nxt = {IDLE_WORD, HDR_IDLE};
    if (pop) begin
      frame_nxt = {mem[rd_ptr], HDR_DATA};
    end
  end

  // Window top bit: delay d selects hist[63-d : 32-d], so the low d output
  // bits are the top d bits of the older word -- the stream runs d bits late.
  assign top_idx = 6'd63 - {1'b0, delay};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_w <= '0;
      hist    <= '0;
      dataout <= '0;
      delay   <= '0;
    end else begin
      frame_w <= frame_nxt;
      // Newest word enters at the top; the older word slides to the bottom.
      hist    <= {frame_w, hist[63:32]};
      dataout <= hist[top_idx -: 32];
      // Natural 5-bit wrap 31 -> 0 advances the stream by 31 bits, mirroring
      // the receiver's own counter wrap.
      if (slip_later) begin
        delay <= delay + 5'd1;
      end
    end
  end

endmodule
